expansion_input_debounce: RTL and testbench
===========================================

# expansion_input_debounce

Per-bit debounce and edge-detect stage that consumes the parallel input word assembled by the expansion shift-register driver (`data_in` of the 74HC165-style chain). It sits directly downstream of that driver. The driver updates the word one bit at a time on its own generated shift clock, so this block synchronizes every bit into `clk` and filters contact bounce. It then presents a clean, stable input word plus single-cycle rise, fall and change strobes to the rest of the design.

## Interface
- `WIDTH`, 8: number of expansion input bits; 1..64.
- `TICK_DIV`, 1000: `clk` cycles per debounce sample tick; 1..2^20. A value of 1 means a tick every cycle.
- `DEBOUNCE`, 16: consecutive disagreeing ticks required to accept a new level; 1..65535.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `data_raw` in WIDTH: raw input word from the shift-register driver; treated as asynchronous to `clk`.
- `data_stable` out WIDTH: debounced input levels.
- `rise` out WIDTH: one-cycle pulse per bit when that bit's `data_stable` goes 0→1.
- `fall` out WIDTH: one-cycle pulse per bit when that bit's `data_stable` goes 1→0.
- `changed` out 1: one-cycle pulse, the OR of all `rise|fall` bits.
- `change_count` out 16: number of `changed` pulses since reset; wraps.

## Operation
- **Synchronizer:** two flops per bit, `data_raw → s1 → s2`, reset to 0. All downstream logic uses only `s2`.
- **Prescaler:** `presc` counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle where `presc == TICK_DIV-1`. With TICK_DIV=1, `tick` is always high.
- **Per-bit filter:** state is `stable` (1 bit) and `cnt` (ceil(log2(DEBOUNCE+1)) bits, minimum 1). It is evaluated only when `tick` is high.
  - If `s2 == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE-1`: `stable <= s2`, `cnt <= 0`, and the rise or fall pulse for that bit is asserted next cycle.
  - Else: `cnt <= cnt+1`.
  - When `tick` is low, `stable` and `cnt` hold.
- **Bounce rejection:** if `s2` returns to `stable` before acceptance, the counter clears on the next tick and no pulse is produced.
- **Bit independence:** bits are fully independent. Several bits may pulse in the same cycle, and `changed` is still a single pulse.
- **`change_count`:** increments by 1 per `changed` cycle, regardless of how many bits changed. Wraps 0xFFFF→0x0000.
- **Reset values:** `s1`, `s2`, `stable`, `cnt`, `presc`, `data_stable`, `rise`, `fall`, `changed` and `change_count` are all 0. `rst` mid-count discards the partial count. After release, an input already at 1 produces a normal debounced `rise`.
- **Out-of-range parameters:** DEBOUNCE=0 or TICK_DIV=0 is illegal. Elaboration fails via an assertion.

## Timing
- Edge numbering: `data_raw` changes before edge 0; `s1` captures at edge 0; `s2` captures at edge 1.
- **TICK_DIV=1:** the first evaluation that sees the new `s2` is at edge 2. `data_stable` updates at edge 1+DEBOUNCE, and `rise`/`fall`/`changed` are high in the cycle after that same edge. Total latency is DEBOUNCE+2 cycles to visible output.
- **General TICK_DIV:** latency is 2 plus between (DEBOUNCE-1)·TICK_DIV+1 and DEBOUNCE·TICK_DIV cycles, depending on prescaler phase.
- **Pulse shape:** pulses are exactly one `clk` wide. `data_stable` and the pulse for a given change appear in the same cycle.
- **Outputs:** all outputs are registered, with no combinational path from `data_raw`.

## Structure
- **Shared package `expansion_pkg`:**
  - `clog2`-based width function.
  - Default constants `EXP_WIDTH=8`, `EXP_TICK_DIV=1000`, `EXP_DEBOUNCE=16`, which the shift-register driver also uses.
- **Sub-module `expansion_debounce_bit`:** one instance per bit, generated over WIDTH.
  - Ports: `clk`, `rst`, `tick`, `in_sync`, `stable`, `rise`, `fall`.
  - The synchronizer, prescaler, `changed` OR-reduce and `change_count` stay in the top.

## Test plan
- **Reset:** WIDTH=8, TICK_DIV=1, DEBOUNCE=4. Assert `rst` with `data_raw`=0xFF, then release → all outputs 0 during reset. `data_stable`=0xFF and `rise`=0xFF for one cycle, 6 cycles after release. `change_count`=1.
- **Clean edge latency:** same parameters, `data_raw` 0x00→0x01 → `data_stable`=0x01 and `rise`=0x01 exactly 6 cycles later. `fall`=0, `changed`=1 for one cycle.
- **Bounce rejection:** same parameters, bit 3 high for 3 cycles then low → no pulse and `data_stable` unchanged. Hold high for 4+ cycles → `rise`=0x08.
- **Prescaled:** TICK_DIV=10, DEBOUNCE=3, bit 0 toggled to 1 → `data_stable[0]` updates between 23 and 32 cycles later. The rise pulse is one cycle wide.
- **Simultaneous bits:** bits 0 and 7 fall in the same cycle → `fall`=0x81 in one cycle, a single `changed` pulse, and `change_count` +1.
- **Wrap and mid-count reset:**
  - Force 65536 changes → `change_count` returns to 0x0000.
  - Assert `rst` at `cnt`=2 of 4 → no pulse, and the count restarts after release.

Source files
------------

// File: rtl/expansion_pkg.sv
// expansion_pkg: shared constants and width helper for the expansion input chain
package expansion_pkg;
   localparam int EXP_WIDTH    = 8;
   localparam int EXP_TICK_DIV = 1000;
   localparam int EXP_DEBOUNCE = 16;
   function automatic int exp_bits(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/expansion_debounce_bit.sv
// expansion_debounce_bit: tick-sampled debounce filter for one synchronized input bit
module expansion_debounce_bit
   import expansion_pkg::*;
#(
   parameter int DEBOUNCE = EXP_DEBOUNCE
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic in_sync,
   output logic stable,
   output logic rise,
   output logic fall
);
   localparam int CW = exp_bits(DEBOUNCE + 1);
   logic [CW-1:0] r_cnt;
   logic          r_stable;
   logic          r_rise;
   logic          r_fall;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
         r_rise   <= 1'b0;
         r_fall   <= 1'b0;
      end else begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         if (tick) begin
            if (in_sync == r_stable) begin
               r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE - 1)) begin
               r_stable <= in_sync;
               r_cnt    <= '0;
               r_rise   <= in_sync;
               r_fall   <= ~in_sync;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end
   end
   assign stable = r_stable;
   assign rise   = r_rise;
   assign fall   = r_fall;
endmodule

// File: rtl/expansion_input_debounce.sv
// expansion_input_debounce: synchronizes and debounces the expansion input word,
// producing a clean word plus rise/fall/changed strobes and a change counter
module expansion_input_debounce
   import expansion_pkg::*;
#(
   parameter int WIDTH    = EXP_WIDTH,
   parameter int TICK_DIV = EXP_TICK_DIV,
   parameter int DEBOUNCE = EXP_DEBOUNCE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] data_raw,
   output logic [WIDTH-1:0] data_stable,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed,
   output logic [15:0]      change_count
);
   localparam int PW = exp_bits(TICK_DIV);
   if (DEBOUNCE < 1 || TICK_DIV < 1) begin : g_bad_param
      $error("expansion_input_debounce: DEBOUNCE and TICK_DIV must be at least 1");
   end
   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [PW-1:0]    r_presc;
   logic [15:0]      r_count;
   logic             w_tick;
   assign w_tick = r_presc == PW'(TICK_DIV - 1);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1    <= '0;
         r_s2    <= '0;
         r_presc <= '0;
         r_count <= '0;
      end else begin
         r_s1    <= data_raw;
         r_s2    <= r_s1;
         r_presc <= w_tick ? '0 : r_presc + 1'b1;
         r_count <= r_count + 16'(changed);
      end
   end
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      expansion_debounce_bit #(.DEBOUNCE(DEBOUNCE)) u_bit (
         .clk    (clk),
         .rst    (rst),
         .tick   (w_tick),
         .in_sync(r_s2[i]),
         .stable (data_stable[i]),
         .rise   (rise[i]),
         .fall   (fall[i])
      );
   end
   // rise/fall are registered, so the OR stays a registered-output function
   assign changed      = |(rise | fall);
   assign change_count = r_count;
endmodule

// File: tb/tb_expansion_input_debounce.sv
// tb_expansion_input_debounce: three parameterisations checked against a run-length
// reference model every cycle, plus literal latency/pulse expectations
module tb_expansion_input_debounce;
   logic        clk;
   logic        rst;
   logic [7:0]  raw [3];
   logic [7:0]  ds  [3];
   logic [7:0]  ri  [3];
   logic [7:0]  fa  [3];
   logic        ch  [3];
   logic [15:0] cc  [3];
   int checks = 0;
   int errors = 0;

   expansion_input_debounce #(.WIDTH(8), .TICK_DIV(1), .DEBOUNCE(4)) u_a (
      .clk(clk), .rst(rst), .data_raw(raw[0]), .data_stable(ds[0]), .rise(ri[0]),
      .fall(fa[0]), .changed(ch[0]), .change_count(cc[0]));
   expansion_input_debounce #(.WIDTH(8), .TICK_DIV(10), .DEBOUNCE(3)) u_b (
      .clk(clk), .rst(rst), .data_raw(raw[1]), .data_stable(ds[1]), .rise(ri[1]),
      .fall(fa[1]), .changed(ch[1]), .change_count(cc[1]));
   expansion_input_debounce #(.WIDTH(8), .TICK_DIV(1), .DEBOUNCE(1)) u_c (
      .clk(clk), .rst(rst), .data_raw(raw[2]), .data_stable(ds[2]), .rise(ri[2]),
      .fall(fa[2]), .changed(ch[2]), .change_count(cc[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int td(input int m);
      return (m == 1) ? 10 : 1;
   endfunction
   function automatic int db(input int m);
      return (m == 0) ? 4 : (m == 1) ? 3 : 1;
   endfunction

   // reference: s2 is raw delayed two edges; a bit flips once DEBOUNCE tick
   // samples in a row have disagreed with the accepted level
   logic [7:0]  m_s1 [3];
   logic [7:0]  m_s2 [3];
   logic [7:0]  m_st [3];
   logic [7:0]  m_ri [3];
   logic [7:0]  m_fa [3];
   logic [15:0] m_cc [3];
   int          m_e  [3];
   int          m_run[3][8];

   task automatic model_step();
      for (int m = 0; m < 3; m++) begin
         if (rst) begin
            m_s1[m] = 0; m_s2[m] = 0; m_st[m] = 0; m_ri[m] = 0; m_fa[m] = 0;
            m_cc[m] = 0; m_e[m] = 0;
            for (int b = 0; b < 8; b++) m_run[m][b] = 0;
         end else begin
            if ((m_ri[m] | m_fa[m]) != 0) m_cc[m] = m_cc[m] + 16'd1;
            m_ri[m] = 0;
            m_fa[m] = 0;
            if (m_e[m] % td(m) == td(m) - 1) begin
               for (int b = 0; b < 8; b++) begin
                  m_run[m][b] = (m_s2[m][b] != m_st[m][b]) ? m_run[m][b] + 1 : 0;
                  if (m_run[m][b] == db(m)) begin
                     m_run[m][b] = 0;
                     m_st[m][b]  = m_s2[m][b];
                     if (m_s2[m][b]) m_ri[m][b] = 1'b1;
                     else m_fa[m][b] = 1'b1;
                  end
               end
            end
            m_e[m]  = m_e[m] + 1;
            m_s2[m] = m_s1[m];
            m_s1[m] = raw[m];
         end
      end
   endtask

   initial begin
      #0;
      forever begin
         @(posedge clk or posedge rst);
         model_step();
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int m = 0; m < 3; m++) begin
            chk($sformatf("stable%0d", m), 32'(ds[m]), 32'(m_st[m]));
            chk($sformatf("rise%0d", m), 32'(ri[m]), 32'(m_ri[m]));
            chk($sformatf("fall%0d", m), 32'(fa[m]), 32'(m_fa[m]));
            chk($sformatf("changed%0d", m), 32'(ch[m]), 32'((m_ri[m] | m_fa[m]) != 0));
            chk($sformatf("count%0d", m), 32'(cc[m]), 32'(m_cc[m]));
         end
      end
   end

   task automatic drive(input int m, input logic [7:0] v);
      @(posedge clk);
      #2;
      raw[m] = v;
   endtask

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // samples #1 after each edge; returns index of first sample with a pulse in msk, or -1
   task automatic wait_for(input int m, input logic [7:0] msk, input int bound, output int n);
      n = -1;
      for (int i = 1; i <= bound; i++) begin
         @(posedge clk);
         #1;
         if (((ri[m] | fa[m]) & msk) != 0) begin
            n = i;
            break;
         end
      end
   endtask

   int n;
   logic [15:0] c0;

   initial begin
      rst = 1'b1;
      raw[0] = 8'hFF; raw[1] = 8'h00; raw[2] = 8'h00;
      settle(3);
      chk("reset_stable", 32'(ds[0]), 32'h00);
      chk("reset_rise", 32'(ri[0]), 32'h00);
      chk("reset_count", 32'(cc[0]), 32'h0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_for(0, 8'hFF, 20, n);
      chk("reset_rise_latency", 32'(n), 32'd6);
      chk("reset_rise_val", 32'(ri[0]), 32'hFF);
      chk("reset_stable_val", 32'(ds[0]), 32'hFF);
      settle(1);
      chk("reset_rise_width", 32'(ri[0]), 32'h00);
      chk("reset_count_one", 32'(cc[0]), 32'h1);

      drive(0, 8'h00);
      settle(12);
      drive(0, 8'h01);
      wait_for(0, 8'hFF, 20, n);
      chk("edge_latency", 32'(n), 32'd6);
      chk("edge_rise", 32'(ri[0]), 32'h01);
      chk("edge_fall", 32'(fa[0]), 32'h00);
      chk("edge_changed", 32'(ch[0]), 32'h1);
      chk("edge_stable", 32'(ds[0]), 32'h01);
      settle(1);
      chk("edge_changed_width", 32'(ch[0]), 32'h0);

      drive(0, 8'h09);
      settle(2);
      drive(0, 8'h01);
      wait_for(0, 8'hFF, 12, n);
      chk("bounce_no_pulse", 32'(n), 32'hFFFF_FFFF);
      chk("bounce_stable", 32'(ds[0]), 32'h01);
      drive(0, 8'h09);
      wait_for(0, 8'hFF, 20, n);
      chk("bounce_accept_latency", 32'(n), 32'd6);
      chk("bounce_accept_rise", 32'(ri[0]), 32'h08);

      drive(0, 8'h81);
      settle(12);
      c0 = cc[0];
      drive(0, 8'h00);
      wait_for(0, 8'hFF, 20, n);
      chk("simul_latency", 32'(n), 32'd6);
      chk("simul_fall", 32'(fa[0]), 32'h81);
      chk("simul_rise", 32'(ri[0]), 32'h00);
      chk("simul_changed", 32'(ch[0]), 32'h1);
      settle(1);
      chk("simul_changed_width", 32'(ch[0]), 32'h0);
      chk("simul_count", 32'(cc[0]), 32'(c0 + 16'd1));

      drive(0, 8'h01);
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      settle(2);
      chk("midrst_stable", 32'(ds[0]), 32'h00);
      chk("midrst_rise", 32'(ri[0]), 32'h00);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_for(0, 8'hFF, 20, n);
      chk("midrst_restart_latency", 32'(n), 32'd6);
      chk("midrst_restart_rise", 32'(ri[0]), 32'h01);

      drive(1, 8'h01);
      wait_for(1, 8'h01, 60, n);
      chk("presc_latency_in_range", 32'(n >= 23 && n <= 32), 32'h1);
      chk("presc_stable", 32'(ds[1]), 32'h01);
      settle(1);
      chk("presc_rise_width", 32'(ri[1]), 32'h00);

      for (int it = 0; it < 300; it++) begin
         drive(0, 8'($urandom));
         raw[1] = 8'($urandom);
         repeat ($urandom_range(0, 14)) @(posedge clk);
      end
      settle(40);

      for (int i = 0; i < 65535; i++) drive(2, raw[2] ^ 8'h01);
      settle(6);
      chk("wrap_ffff", 32'(cc[2]), 32'h0000_FFFF);
      drive(2, raw[2] ^ 8'h01);
      settle(6);
      chk("wrap_zero", 32'(cc[2]), 32'h0000_0000);

      settle(2);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
